// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer: FSM state encoding,
// population count and lowest-index one-hot selection over a bounded channel vector.
package rvfi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DONE,
    S_TIMEOUT,
    S_ABORT
  } seq_state_e;

  // Upper bound on retirement channels; callers zero-extend narrower vectors.
  localparam int unsigned MAX_NRET = 32;

  function automatic int unsigned popcount(input logic [MAX_NRET-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_NRET; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [MAX_NRET-1:0] prio_onehot(input logic [MAX_NRET-1:0] v);
    return v & (~v + MAX_NRET'(1));
  endfunction

endpackage

// File: rtl/rvfi_seq_prio.sv
// Lowest-index one-hot priority selector over NRET request lines.
module rvfi_seq_prio
  import rvfi_seq_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic [NRET-1:0] req_i,
  output logic [NRET-1:0] grant_o
);

  assign grant_o = NRET'(prio_onehot(MAX_NRET'(req_i)));

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Arms on start, waits for the target rvfi_order to retire on any channel and
// fires a one-hot check to the per-channel checkers, or gives up on halt/timeout.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ORDER_W-1:0]      target_order,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET-1:0]         rvfi_halt,
  output logic [NRET-1:0]         check,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    aborted,
  output logic                    dup_err,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  seq_state_e         state_q;
  logic [ORDER_W-1:0] target_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, timeout_q, aborted_q, dup_q;

  logic [NRET-1:0]    match;
  logic               armed, any_match, any_halt, multi_match, wait_end;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input int unsigned b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign armed = (state_q == S_ARMED);

  always_comb begin
    match = '0;
    for (int c = 0; c < NRET; c++) begin
      match[c] = armed && rvfi_valid[c] &&
                 (rvfi_order[c*ORDER_W +: ORDER_W] == target_q);
    end
  end

  rvfi_seq_prio #(.NRET(NRET)) u_prio (
    .req_i  (match),
    .grant_o(check)
  );

  assign any_match   = |match;
  assign any_halt    = |(rvfi_valid & rvfi_halt);
  assign multi_match = popcount(MAX_NRET'(match)) > 1;
  assign wait_end    = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign wait_d      = wait_q + WAIT_W'(1);
  assign cnt_d       = sat_add(cnt_q, popcount(MAX_NRET'(rvfi_valid)));

  // Priority inside ARMED: match, then halt, then timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          cnt_q  <= cnt_d;
          wait_q <= wait_d;
          if (any_match) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            dup_q   <= multi_match;
          end else if (any_halt) begin
            state_q   <= S_ABORT;
            aborted_q <= 1'b1;
          end else if (wait_end) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q   <= S_ARMED;
            target_q  <= target_order;
            wait_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            dup_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy       = armed;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign aborted    = aborted_q;
  assign dup_err    = dup_q;
  assign retire_cnt = cnt_q;

endmodule
